// File: rtl/rf_pkg.sv
// Register-file wide constants shared by the write queue and the register file.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rf_write_queue_if.sv
// Writeback-to-queue request channel: valid/ready handshake carrying one register write.
interface rf_write_queue_if
  import rf_pkg::*;
#(
  parameter int AW = REG_ADDR_W,
  parameter int DW = REG_DATA_W
) ();
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_reg, output in_data, input in_ready);
  modport slave  (input in_valid, input in_reg, input in_data, output in_ready);
endinterface

// File: rtl/rf_fwd_match.sv
// One forwarding lookup port: finds the youngest valid queue entry targeting a register.
module rf_fwd_match
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_ADDR_W,
  parameter int DW    = REG_DATA_W,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] regs,
  input  logic [DEPTH-1:0][DW-1:0] datas,
  input  logic [DEPTH-1:0][PW-1:0] ages,
  input  logic [AW-1:0]            lookup,
  output logic                     hit,
  output logic [DW-1:0]            data
);
  logic [PW-1:0] best;

  // Ages are unique per entry, so the largest age among matches is the youngest write.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    best = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (regs[i] == lookup) && (lookup != AW'(ZERO_REG)) &&
          (!hit || (ages[i] > best))) begin
        hit  = 1'b1;
        best = ages[i];
        data = datas[i];
      end
    end
  end
endmodule

// File: rtl/rf_write_queue.sv
// Buffers writeback register writes and drains one per cycle into the register file,
// with two forwarding lookups over the still-queued entries.
module rf_write_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_ADDR_W,
  parameter int DW    = REG_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  rf_write_queue_if.slave            wr,
  input  logic                       hold,
  output logic                       rf_write_en,
  output logic [AW-1:0]              rf_write_reg,
  output logic [DW-1:0]              rf_write_data,
  input  logic [AW-1:0]              fwd_reg_1,
  input  logic [AW-1:0]              fwd_reg_2,
  output logic                       fwd_hit_1,
  output logic                       fwd_hit_2,
  output logic [DW-1:0]              fwd_data_1,
  output logic [DW-1:0]              fwd_data_2,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][AW-1:0] mem_reg;
  logic [DEPTH-1:0][DW-1:0] mem_data;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [DEPTH-1:0][PW-1:0] ages;
  logic [DEPTH-1:0]         valid;
  logic                     push;
  logic                     enq;
  logic                     pop;

  assign wr.in_ready   = (count < CW'(DEPTH));
  assign push          = wr.in_valid && wr.in_ready;
  // Register 0 is hardwired zero: the handshake completes but nothing is stored.
  assign enq           = push && (wr.in_reg != AW'(ZERO_REG));
  assign rf_write_en   = (count != '0) && !hold;
  assign pop           = rf_write_en;
  assign rf_write_reg  = mem_reg[head];
  assign rf_write_data = mem_data[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_reg  <= '0;
      mem_data <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        mem_reg[tail]  <= wr.in_reg;
        mem_data[tail] <= wr.in_data;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Age is distance from head; an entry is live when its age is below the fill count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ages[i]  = PW'(i) - head;
      valid[i] = (CW'(ages[i]) < count);
    end
  end

  rf_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_1 (
    .valid  (valid),
    .regs   (mem_reg),
    .datas  (mem_data),
    .ages   (ages),
    .lookup (fwd_reg_1),
    .hit    (fwd_hit_1),
    .data   (fwd_data_1)
  );

  rf_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_2 (
    .valid  (valid),
    .regs   (mem_reg),
    .datas  (mem_data),
    .ages   (ages),
    .lookup (fwd_reg_2),
    .hit    (fwd_hit_2),
    .data   (fwd_data_2)
  );
endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: vector table, queue-model monitor, reset corners.
module tb_rf_write_queue;
  import rf_pkg::*;

  typedef struct {
    int hold, valid, rg, data, f1, f2;
    int cnt, rdy, en, wreg, h1, d1, h2, d2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        rf_write_en;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [4:0]  fwd_reg_1 = '0;
  logic [4:0]  fwd_reg_2 = '0;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data_1, fwd_data_2;
  logic [2:0]  count;

  int          errors = 0;
  int          checks = 0;
  int          writes = 0;
  bit          mon_en = 1'b0;
  logic [36:0] sb[$];
  vec_t        tv[18];

  rf_write_queue_if #(.AW(5), .DW(32)) wr_if ();

  rf_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr            (wr_if),
    .hold          (hold),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .fwd_reg_1     (fwd_reg_1),
    .fwd_reg_2     (fwd_reg_2),
    .fwd_hit_1     (fwd_hit_1),
    .fwd_hit_2     (fwd_hit_2),
    .fwd_data_1    (fwd_data_1),
    .fwd_data_2    (fwd_data_2),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int hold_v, int valid_v, int rg, int data, int f1, int f2,
                              int cnt, int rdy, int en, int wreg, int h1, int d1, int h2, int d2);
    vec_t v;
    v.hold = hold_v; v.valid = valid_v; v.rg = rg; v.data = data; v.f1 = f1; v.f2 = f2;
    v.cnt = cnt; v.rdy = rdy; v.en = en; v.wreg = wreg;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    return v;
  endfunction

  // Youngest queued write to r (r0 never matches).
  function automatic void model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (!hit && r != 5'd0 && sb[i][36:32] == r) begin
        hit = 1'b1;
        d   = sb[i][31:0];
      end
    end
  endfunction

  // Monitor: compares DUT against the queue model every cycle, pops on writes, pushes on accepts.
  always @(negedge clk) begin : mon
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
    if (mon_en && rst) begin
      model_fwd(fwd_reg_1, eh1, ed1);
      model_fwd(fwd_reg_2, eh2, ed2);
      chk("mon_count", 32'(count), 32'(sb.size()));
      chk("mon_in_ready", 32'(wr_if.in_ready), 32'(sb.size() < 4));
      chk("mon_write_en", 32'(rf_write_en), 32'((sb.size() != 0) && !hold));
      chk("mon_fwd_hit_1", 32'(fwd_hit_1), 32'(eh1));
      chk("mon_fwd_data_1", fwd_data_1, ed1);
      chk("mon_fwd_hit_2", 32'(fwd_hit_2), 32'(eh2));
      chk("mon_fwd_data_2", fwd_data_2, ed2);
      if (rf_write_en) begin
        writes++;
        if (sb.size() != 0) begin
          chk("mon_write_reg", 32'(rf_write_reg), 32'(sb[0][36:32]));
          chk("mon_write_data", rf_write_data, sb[0][31:0]);
          void'(sb.pop_front());
        end
      end
      if (wr_if.in_valid && wr_if.in_ready && wr_if.in_reg != 5'd0)
        sb.push_back({wr_if.in_reg, wr_if.in_data});
    end
  end

  task automatic drive(input int h, input int v, input int rg, input int d);
    hold           = h[0];
    wr_if.in_valid = v[0];
    wr_if.in_reg   = 5'(rg);
    wr_if.in_data  = 32'(d);
  endtask

  initial begin
    int base;
    drive(0, 0, 0, 0);

    // Columns: hold valid reg data | fwd1 fwd2 | count ready en wreg hit1 data1 hit2 data2
    tv[0]  = mk(0,1,1,'h75, 1,0, 0,1,0,0, 0,0,    0,0);
    tv[1]  = mk(0,1,2,'hD5, 1,2, 1,1,1,1, 1,'h75, 0,0);
    tv[2]  = mk(0,1,3,'h57, 1,2, 1,1,1,2, 0,0,    1,'hD5);
    tv[3]  = mk(0,0,0,0,    3,2, 1,1,1,3, 1,'h57, 0,0);
    tv[4]  = mk(0,0,0,0,    3,0, 0,1,0,0, 0,0,    0,0);
    tv[5]  = mk(0,1,0,'h55, 0,0, 0,1,0,0, 0,0,    0,0);
    tv[6]  = mk(0,0,0,0,    0,0, 0,1,0,0, 0,0,    0,0);
    tv[7]  = mk(1,1,4,'h44, 4,0, 0,1,0,0, 0,0,    0,0);
    tv[8]  = mk(1,1,5,'h11, 4,0, 1,1,0,0, 1,'h44, 0,0);
    tv[9]  = mk(1,1,5,'h22, 5,4, 2,1,0,0, 1,'h11, 1,'h44);
    tv[10] = mk(1,1,7,'h77, 5,6, 3,1,0,0, 1,'h22, 0,0);
    tv[11] = mk(1,1,9,'h99, 5,7, 4,0,0,0, 1,'h22, 1,'h77);
    tv[12] = mk(0,1,9,'h99, 4,7, 4,0,1,4, 1,'h44, 1,'h77);
    tv[13] = mk(0,1,9,'h99, 4,9, 3,1,1,5, 0,0,    0,0);
    tv[14] = mk(0,0,0,0,    5,9, 3,1,1,5, 1,'h22, 1,'h99);
    tv[15] = mk(0,0,0,0,    5,9, 2,1,1,7, 0,0,    1,'h99);
    tv[16] = mk(0,0,0,0,    7,9, 1,1,1,9, 0,0,    1,'h99);
    tv[17] = mk(0,0,0,0,    0,9, 0,1,0,0, 0,0,    0,0);

    // Reset held low for four cycles.
    fwd_reg_1 = 5'd1;
    fwd_reg_2 = 5'd2;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(wr_if.in_ready), 1);
    chk("rst_write_en", 32'(rf_write_en), 0);
    chk("rst_write_reg", 32'(rf_write_reg), 0);
    chk("rst_write_data", rf_write_data, 0);
    chk("rst_fwd_hit_1", 32'(fwd_hit_1), 0);
    chk("rst_fwd_data_2", fwd_data_2, 0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    foreach (tv[i]) begin
      @(posedge clk);
      #1;
      drive(tv[i].hold, tv[i].valid, tv[i].rg, tv[i].data);
      fwd_reg_1 = 5'(tv[i].f1);
      fwd_reg_2 = 5'(tv[i].f2);
      @(negedge clk);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("v%0d_in_ready", i), 32'(wr_if.in_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_write_en", i), 32'(rf_write_en), 32'(tv[i].en));
      if (tv[i].en != 0)
        chk($sformatf("v%0d_write_reg", i), 32'(rf_write_reg), 32'(tv[i].wreg));
      chk($sformatf("v%0d_fwd_hit_1", i), 32'(fwd_hit_1), 32'(tv[i].h1));
      chk($sformatf("v%0d_fwd_data_1", i), fwd_data_1, 32'(tv[i].d1));
      chk($sformatf("v%0d_fwd_hit_2", i), 32'(fwd_hit_2), 32'(tv[i].h2));
      chk($sformatf("v%0d_fwd_data_2", i), fwd_data_2, 32'(tv[i].d2));
    end

    // Random traffic with pointer wrap, concurrent push/pop and duplicate targets.
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      drive(($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom));
      fwd_reg_1 = 5'($urandom_range(0, 7));
      fwd_reg_2 = 5'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("drain_count", 32'(count), 0);

    // Reset while draining: pending writes must be discarded.
    drive(1, 1, 10, 'hA0);
    @(posedge clk); #1;
    drive(1, 1, 11, 'hB0);
    @(posedge clk); #1;
    drive(1, 1, 12, 'hC0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    fwd_reg_1 = 5'd11;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    base = writes;
    #1;
    chk("midrst_write_en", 32'(rf_write_en), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_in_ready", 32'(wr_if.in_ready), 1);
    chk("midrst_fwd_hit_1", 32'(fwd_hit_1), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_writes", 32'(writes), 32'(base));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
